// File: rtl/up_down_count_checker_if.sv
// ---------------------------------------------------------------------------
// up_down_count_checker_if
//   Bundles the observed counter signals and the checker's status outputs.
//   master : the counter side (drives mode/count, may read status)
//   slave  : the checker (reads mode/count, drives status)
//
//   mode       counter direction, 1 = up, 0 = down
//   count      observed counter value, WIDTH bits
//   locked     high after LOCK_CYCLES consecutive correct transitions
//   err_pulse  one-cycle pulse on a mispredicted sample
//   err_count  saturating mismatch total
//   up_wraps   correct MAX->0 transitions while counting up (mod 256)
//   down_wraps correct 0->MAX transitions while counting down (mod 256)
//   dir        last sampled mode
// ---------------------------------------------------------------------------
interface up_down_count_checker_if #(
    parameter int WIDTH = 4
);
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             locked;
    logic             err_pulse;
    logic [7:0]       err_count;
    logic [7:0]       up_wraps;
    logic [7:0]       down_wraps;
    logic             dir;

    modport master (
        output mode,
        output count,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  up_wraps,
        input  down_wraps,
        input  dir
    );

    modport slave (
        input  mode,
        input  count,
        output locked,
        output err_pulse,
        output err_count,
        output up_wraps,
        output down_wraps,
        output dir
    );
endinterface

// File: rtl/up_down_count_checker.sv
// ---------------------------------------------------------------------------
// up_down_count_checker
//   Passive monitor for an up/down counter. Each clock it compares the
//   observed count against the value predicted from the previous sample,
//   reports lock status, flags and tallies mismatches, and counts correct
//   wrap-around transitions in each direction. All outputs are registered.
//
//   Ports:
//     clk    rising-edge clock shared with the counter
//     reset  asynchronous, active-high reset shared with the counter
//     bus    slave modport: mode/count in; locked, err_pulse, err_count,
//            up_wraps, down_wraps, dir out
// ---------------------------------------------------------------------------
module up_down_count_checker #(
    parameter int WIDTH       = 4,
    parameter int LOCK_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    up_down_count_checker_if.slave   bus
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_RUN = 4'(LOCK_CYCLES);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ACQ   = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_ref_count;
    logic             r_ref_mode;
    logic [3:0]       r_run;
    logic             r_locked;
    logic             r_err_pulse;
    logic [7:0]       r_err_count;
    logic [7:0]       r_up_wraps;
    logic [7:0]       r_down_wraps;
    logic             r_dir;

    logic [WIDTH-1:0] w_exp;
    logic             w_match;
    logic             w_up_wrap;
    logic             w_down_wrap;
    logic [3:0]       w_run_next;

    function automatic logic [WIDTH-1:0] predict(input logic [WIDTH-1:0] ref_cnt,
                                                 input logic             ref_up);
        return ref_up ? (ref_cnt + CNT_ONE) : (ref_cnt - CNT_ONE);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : (val + 8'd1);
    endfunction

    assign w_exp       = predict(r_ref_count, r_ref_mode);
    assign w_match     = (bus.count == w_exp);
    // A wrap can only be reached through a correct prediction, so these
    // are qualified with w_match in the update below.
    assign w_up_wrap   = r_ref_mode  && (r_ref_count == CNT_MAX)  && (bus.count == CNT_ZERO);
    assign w_down_wrap = !r_ref_mode && (r_ref_count == CNT_ZERO) && (bus.count == CNT_MAX);
    assign w_run_next  = r_run + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_EMPTY;
            r_ref_count  <= '0;
            r_ref_mode   <= 1'b0;
            r_run        <= 4'd0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_count  <= 8'd0;
            r_up_wraps   <= 8'd0;
            r_down_wraps <= 8'd0;
            r_dir        <= 1'b0;
        end else begin
            // The observed sample always becomes the next reference, which
            // also gives immediate resync after a mismatch.
            r_ref_count <= bus.count;
            r_ref_mode  <= bus.mode;
            r_dir       <= bus.mode;
            r_err_pulse <= 1'b0;

            case (r_state)
                S_EMPTY: begin
                    r_state <= S_ACQ;
                    r_run   <= 4'd0;
                end
                S_ACQ, S_LOCK: begin
                    if (w_match) begin
                        if (r_state == S_ACQ) begin
                            r_run <= w_run_next;
                            if (w_run_next == LOCK_RUN) begin
                                r_state  <= S_LOCK;
                                r_locked <= 1'b1;
                            end
                        end
                        if (w_up_wrap) begin
                            r_up_wraps <= r_up_wraps + 8'd1;
                        end
                        if (w_down_wrap) begin
                            r_down_wraps <= r_down_wraps + 8'd1;
                        end
                    end else begin
                        r_err_pulse <= 1'b1;
                        r_err_count <= sat_inc8(r_err_count);
                        r_locked    <= 1'b0;
                        r_run       <= 4'd0;
                        r_state     <= S_ACQ;
                    end
                end
                default: begin
                    r_state  <= S_EMPTY;
                    r_run    <= 4'd0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.locked     = r_locked;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_count  = r_err_count;
    assign bus.up_wraps   = r_up_wraps;
    assign bus.down_wraps = r_down_wraps;
    assign bus.dir        = r_dir;

endmodule

// File: tb/tb_up_down_count_checker.sv
// ---------------------------------------------------------------------------
// tb_up_down_count_checker
//   Scoreboard bench: stimulus drives count/mode on the falling edge and
//   pushes the expected status into a queue; the monitor pops one entry per
//   rising edge and compares every output field.
// ---------------------------------------------------------------------------
module tb_up_down_count_checker;

    localparam int W    = 4;
    localparam int LC   = 4;
    localparam int MODV = 1 << W;
    localparam int MAXV = MODV - 1;

    typedef struct packed {
        logic       locked;
        logic       err_pulse;
        logic [7:0] err_count;
        logic [7:0] up_wraps;
        logic [7:0] down_wraps;
        logic       dir;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    up_down_count_checker_if #(.WIDTH(W)) bus ();

    up_down_count_checker #(
        .WIDTH       (W),
        .LOCK_CYCLES (LC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: history of the observed sequence summarised as plain
    // integers (streak of good transitions, total errors, wrap tallies).
    bit have_ref;
    int prev_c;
    int prev_m;
    int streak;
    int errs;
    int upw;
    int dnw;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int next_exp();
        return prev_m != 0 ? (prev_c + 1) % MODV : (prev_c + MODV - 1) % MODV;
    endfunction

    task automatic model_reset();
        have_ref = 1'b0;
        prev_c = 0;
        prev_m = 0;
        streak = 0;
        errs   = 0;
        upw    = 0;
        dnw    = 0;
    endtask

    task automatic step_now(input bit m, input int c);
        exp_t e;
        bit   bad;
        bad = 1'b0;
        bus.mode  = m;
        bus.count = W'(c);
        if (!have_ref) begin
            have_ref = 1'b1;
            streak   = 0;
        end else if (c == next_exp()) begin
            streak++;
            if (prev_m == 1 && prev_c == MAXV && c == 0) upw++;
            if (prev_m == 0 && prev_c == 0 && c == MAXV) dnw++;
        end else begin
            bad    = 1'b1;
            errs++;
            streak = 0;
        end
        prev_c = c;
        prev_m = m;
        e.locked     = (streak >= LC);
        e.err_pulse  = bad;
        e.err_count  = 8'((errs > 255) ? 255 : errs);
        e.up_wraps   = 8'(upw % 256);
        e.down_wraps = 8'(dnw % 256);
        e.dir        = m;
        q.push_back(e);
    endtask

    task automatic step(input bit m, input int c);
        @(negedge clk);
        step_now(m, c);
    endtask

    // Counter behaving correctly for n samples in direction m.
    task automatic run(input bit m, input int n);
        for (int i = 0; i < n; i++) begin
            step(m, next_exp());
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_locked"},     8'(bus.locked),    8'd0);
        chk({tag, "_err_pulse"},  8'(bus.err_pulse), 8'd0);
        chk({tag, "_err_count"},  bus.err_count,     8'd0);
        chk({tag, "_up_wraps"},   bus.up_wraps,      8'd0);
        chk({tag, "_down_wraps"}, bus.down_wraps,    8'd0);
        chk({tag, "_dir"},        8'(bus.dir),       8'd0);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_zero(tag);
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    // Monitor: one scoreboard entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked",     8'(bus.locked),    8'(e.locked));
                chk("err_pulse",  8'(bus.err_pulse), 8'(e.err_pulse));
                chk("err_count",  bus.err_count,     e.err_count);
                chk("up_wraps",   bus.up_wraps,      e.up_wraps);
                chk("down_wraps", bus.down_wraps,    e.down_wraps);
                chk("dir",        8'(bus.dir),       8'(e.dir));
            end
        end
    end

    initial begin
        model_reset();
        bus.mode  = 1'b1;
        bus.count = '0;
        #2;
        reset = 1'b1;
        #1;
        check_zero("por");
        repeat (2) @(negedge clk);

        // Lock-up from 0 and first up wrap.
        @(negedge clk);
        reset = 1'b0;
        step_now(1'b1, 0);
        for (int i = 1; i <= 4; i++) step(1'b1, i);
        run(1'b1, 11);
        run(1'b1, 2);

        // Direction change and down wrap.
        run(1'b1, 3);
        step(1'b0, 5);
        run(1'b0, 7);
        step(1'b1, 13);
        run(1'b1, 8);

        // Single misprediction then relock from the new reference.
        step(1'b1, 9);
        run(1'b1, 6);

        // Long burst of mispredictions drives err_count into saturation.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), (next_exp() + int'($urandom_range(1, MAXV))) % MODV);
        end
        run(1'b1, 6);

        // Fresh run: 3 errors and 2 up wraps, then reset mid-run.
        async_reset("rst1");
        @(negedge clk);
        reset = 1'b0;
        step_now(1'b1, 0);
        run(1'b1, 20);
        step(1'b1, 9);
        run(1'b1, 10);
        step(1'b1, 7);
        step(1'b0, 12);
        run(1'b0, 3);
        async_reset("rst2");
        @(negedge clk);
        reset = 1'b0;
        step_now(1'b0, 8);
        run(1'b0, 6);

        // Random traffic with direction toggles and occasional faults.
        for (int i = 0; i < 400; i++) begin
            bit m;
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                step(m, (next_exp() + int'($urandom_range(1, MAXV))) % MODV);
            end else begin
                step(m, next_exp());
            end
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
